// File: rtl/wall_engine.sv
// Wall-rectangle hit engine: per-level tables of rectangles tested against the
// scan pixel through a two-stage compare pipeline, with a flushed level switch.
module wall_engine #(
  parameter  int NUM_WALLS  = 32,
  parameter  int NUM_LEVELS = 4,
  parameter  int CW         = 10,
  localparam int IW         = (NUM_WALLS  > 1) ? $clog2(NUM_WALLS)  : 1,
  localparam int LW         = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 update,
  input  logic [LW-1:0]        level,
  input  logic [CW-1:0]        xCount,
  input  logic [CW-1:0]        yCount,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [LW-1:0]        cfg_level,
  input  logic [IW-1:0]        cfg_index,
  input  logic [CW-1:0]        cfg_x,
  input  logic [CW-1:0]        cfg_y,
  input  logic [CW-1:0]        cfg_w,
  input  logic [CW-1:0]        cfg_h,
  input  logic                 cfg_en,
  output logic                 cfg_err,
  output logic [NUM_WALLS-1:0] wall,
  output logic                 wall_any,
  output logic [LW-1:0]        active_level
);

  typedef enum logic {RUN, SWITCH} state_e;

  typedef struct packed {
    logic          en;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [CW-1:0] w;
    logic [CW-1:0] h;
  } entry_t;

  localparam logic [IW:0] NW_LIM = (IW+1)'(NUM_WALLS);
  localparam logic [LW:0] NL_LIM = (LW+1)'(NUM_LEVELS);

  entry_t [NUM_LEVELS-1:0][NUM_WALLS-1:0] tbl_q;
  entry_t [NUM_WALLS-1:0]                 row;
  entry_t                                 cfg_entry;

  state_e                 state_q;
  logic                   sw_cnt_q;
  logic [LW-1:0]          active_level_q;
  logic                   ready_q;
  logic                   err_q;
  logic [NUM_WALLS-1:0]   x_cmp_d, y_cmp_d;
  logic [NUM_WALLS-1:0]   x_cmp_q, y_cmp_q;
  logic [NUM_WALLS-1:0]   hit;
  logic [NUM_WALLS-1:0]   wall_q;
  logic                   wall_any_q;

  logic wr_acc, wr_ok, idx_ok, lvl_ok;
  logic switch_go, flush_d;

  assign cfg_entry = {cfg_en, cfg_x, cfg_y, cfg_w, cfg_h};
  assign idx_ok    = {1'b0, cfg_index} < NW_LIM;
  assign lvl_ok    = {1'b0, cfg_level} < NL_LIM;
  assign wr_acc    = cfg_valid & ready_q;
  assign wr_ok     = wr_acc & idx_ok & lvl_ok;

  // NOTE: the table is ordinary registers, so it is cleared by the async reset;
  // a reset mid-write therefore leaves no half-written entry behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tbl_q <= '0;
    end else if (wr_ok) begin
      tbl_q[cfg_level][cfg_index] <= cfg_entry;
    end
  end

  assign row = tbl_q[active_level_q];

  // Ends are formed one bit wider so x+w past the screen edge clips instead of wrapping.
  for (genvar i = 0; i < NUM_WALLS; i++) begin : g_cmp
    logic [CW:0] x_end, y_end;
    assign x_end      = {1'b0, row[i].x} + {1'b0, row[i].w};
    assign y_end      = {1'b0, row[i].y} + {1'b0, row[i].h};
    assign x_cmp_d[i] = row[i].en && (row[i].x < xCount) && ({1'b0, xCount} < x_end);
    assign y_cmp_d[i] = (row[i].y < yCount) && ({1'b0, yCount} < y_end);
  end

  assign hit       = x_cmp_q & y_cmp_q;
  assign switch_go = update && lvl_in_range(level) && (level != active_level_q);
  // High whenever the state after this edge is SWITCH; outputs are blanked then.
  assign flush_d   = (state_q == RUN) ? switch_go : ~sw_cnt_q;

  function automatic logic lvl_in_range(input logic [LW-1:0] lv);
    return {1'b0, lv} < NL_LIM;
  endfunction

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RUN;
      sw_cnt_q       <= 1'b0;
      active_level_q <= '0;
      ready_q        <= 1'b0;
      err_q          <= 1'b0;
      x_cmp_q        <= '0;
      y_cmp_q        <= '0;
      wall_q         <= '0;
      wall_any_q     <= 1'b0;
    end else begin
      err_q      <= wr_acc & ~wr_ok;
      x_cmp_q    <= x_cmp_d;
      y_cmp_q    <= y_cmp_d;
      wall_q     <= flush_d ? '0 : hit;
      wall_any_q <= ~flush_d & (|hit);
      case (state_q)
        RUN: begin
          ready_q <= 1'b1;
          if (switch_go) begin
            state_q        <= SWITCH;
            active_level_q <= level;
            sw_cnt_q       <= 1'b0;
            ready_q        <= 1'b0;
          end
        end
        SWITCH: begin
          if (sw_cnt_q) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end else begin
            sw_cnt_q <= 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign cfg_ready    = ready_q;
  assign cfg_err      = err_q;
  assign wall         = wall_q;
  assign wall_any     = wall_any_q;
  assign active_level = active_level_q;

endmodule

// File: tb/tb_wall_engine.sv
// Self-checking bench for wall_engine: directed pixel/level checks plus a
// randomized run compared every cycle against a behavioural model.
module tb_wall_engine;

  localparam int NW = 12;
  localparam int NL = 3;
  localparam int CW = 10;
  localparam int IW = 4;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          update = 1'b0;
  logic [LW-1:0] level = '0;
  logic [CW-1:0] xCount = '0, yCount = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [LW-1:0] cfg_level = '0;
  logic [IW-1:0] cfg_index = '0;
  logic [CW-1:0] cfg_x = '0, cfg_y = '0, cfg_w = '0, cfg_h = '0;
  logic          cfg_en = 1'b0;
  logic          cfg_err;
  logic [NW-1:0] wall;
  logic          wall_any;
  logic [LW-1:0] active_level;

  wall_engine #(.NUM_WALLS(NW), .NUM_LEVELS(NL), .CW(CW)) dut (
    .clk(clk), .rst(rst), .update(update), .level(level),
    .xCount(xCount), .yCount(yCount),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_level(cfg_level), .cfg_index(cfg_index),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .cfg_en(cfg_en), .cfg_err(cfg_err),
    .wall(wall), .wall_any(wall_any), .active_level(active_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: the table as plain integers, the level, and how many
  // switch cycles remain. Hits are computed directly from the rectangle rule.
  int m_en[NL][NW], m_x[NL][NW], m_y[NL][NW], m_w[NL][NW], m_h[NL][NW];
  int m_act, m_sw;
  bit m_ready;
  logic [NW-1:0] m_prev_hit;
  logic [NW-1:0] e_wall;
  logic          e_any, e_ready, e_err;
  logic [LW-1:0] e_act;

  function automatic logic [NW-1:0] model_hit(input int px, input int py);
    logic [NW-1:0] h = '0;
    for (int i = 0; i < NW; i++)
      h[i] = (m_en[m_act][i] != 0) &&
             (m_x[m_act][i] < px) && (px < m_x[m_act][i] + m_w[m_act][i]) &&
             (m_y[m_act][i] < py) && (py < m_y[m_act][i] + m_h[m_act][i]);
    return h;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < NL; l++)
      for (int i = 0; i < NW; i++) begin
        m_en[l][i] = 0; m_x[l][i] = 0; m_y[l][i] = 0; m_w[l][i] = 0; m_h[l][i] = 0;
      end
    m_act = 0; m_sw = 0; m_ready = 0; m_prev_hit = '0;
    e_wall = '0; e_any = 0; e_ready = 0; e_err = 0; e_act = '0;
  endtask

  // Advance the model over the coming clock edge using this cycle's inputs.
  task automatic model_step();
    logic [NW-1:0] h;
    int nsw;
    h = model_hit(int'(xCount), int'(yCount));
    e_err = 0;
    if (cfg_valid && m_ready) begin
      if (int'(cfg_level) < NL && int'(cfg_index) < NW) begin
        m_en[cfg_level][cfg_index] = int'(cfg_en);
        m_x[cfg_level][cfg_index]  = int'(cfg_x);
        m_y[cfg_level][cfg_index]  = int'(cfg_y);
        m_w[cfg_level][cfg_index]  = int'(cfg_w);
        m_h[cfg_level][cfg_index]  = int'(cfg_h);
      end else begin
        e_err = 1;
      end
    end
    if (m_sw > 0) nsw = m_sw - 1;
    else if (update && int'(level) < NL && int'(level) != m_act) begin
      m_act = int'(level);
      nsw = 2;
    end else nsw = 0;
    m_sw       = nsw;
    m_ready    = (nsw == 0);
    e_wall     = (nsw > 0) ? '0 : m_prev_hit;
    m_prev_hit = h;
    e_any      = |e_wall;
    e_ready    = m_ready;
    e_act      = LW'(m_act);
  endtask

  // Compare process: every falling edge, outputs vs model, then advance model.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst) model_reset();
      check("model_wall",         wall,         e_wall);
      check("model_wall_any",     wall_any,     e_any);
      check("model_cfg_ready",    cfg_ready,    e_ready);
      check("model_cfg_err",      cfg_err,      e_err);
      check("model_active_level", active_level, e_act);
      if (rst) model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int lv, input int ix, input int en,
                         input int x, input int y, input int w, input int h);
    cfg_level = LW'(lv); cfg_index = IW'(ix); cfg_en = en[0];
    cfg_x = CW'(x); cfg_y = CW'(y); cfg_w = CW'(w); cfg_h = CW'(h);
  endtask

  task automatic cfg_write(input int lv, input int ix, input int en, input int x,
                           input int y, input int w, input int h, output int waited);
    set_cfg(lv, ix, en, x, y, w, h);
    cfg_valid = 1'b1;
    waited = 0;
    while (!cfg_ready && waited < 20) begin
      tick();
      waited++;
    end
    check("cfg_ready_at_accept", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic pix_check(input string name, input int x, input int y,
                           input int idx, input logic exp);
    xCount = CW'(x); yCount = CW'(y);
    tick();
    tick();
    check(name, wall[idx], exp);
  endtask

  initial begin
    int waited;
    bit acc, acc_next;
    int tgt;

    #2 rst = 1'b0;
    #1;
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_wall", wall, 0);
    check("rst_active_level", active_level, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check("ready_before_first_edge", cfg_ready, 0);
    tick();
    check("ready_after_first_edge", cfg_ready, 1);

    // Level 0 entry 0 and its edges.
    cfg_write(0, 0, 1, 5, 46, 600, 20, waited);
    pix_check("hit_6_47",   6,   47, 0, 1'b1);
    check("any_6_47", wall_any, 1);
    pix_check("hit_5_47",   5,   47, 0, 1'b0);
    pix_check("hit_604_47", 604, 47, 0, 1'b1);
    pix_check("hit_605_47", 605, 47, 0, 1'b0);
    pix_check("hit_6_66",   6,   66, 0, 1'b0);

    // Right-edge clipping: x+w = 1100 must not wrap.
    cfg_write(0, 1, 1, 1000, 0, 100, 1023, waited);
    pix_check("clip_1023", 1023, 47, 1, 1'b1);
    pix_check("clip_1000", 1000, 47, 1, 1'b0);

    // Out-of-range index and level.
    cfg_write(0, NW, 1, 0, 0, 1023, 1023, waited);
    check("err_index_pulse", cfg_err, 1);
    tick();
    check("err_index_clear", cfg_err, 0);
    cfg_write(NL, 0, 1, 0, 0, 1023, 1023, waited);
    check("err_level_pulse", cfg_err, 1);
    tick();
    check("err_level_clear", cfg_err, 0);
    pix_check("no_change_after_err", 500, 500, 2, 1'b0);

    // Level switch with flush.
    cfg_write(1, 3, 1, 100, 100, 20, 20, waited);
    xCount = 10'd110; yCount = 10'd110;
    update = 1'b1; level = 2'd1;
    tick();
    update = 1'b0;
    check("switch1_ready", cfg_ready, 0);
    check("switch1_wall", wall, 0);
    check("switch1_level", active_level, 1);
    tick();
    check("switch2_ready", cfg_ready, 0);
    check("switch2_any", wall_any, 0);
    tick();
    check("switch_done_ready", cfg_ready, 1);
    pix_check("l1_hit_110", 110, 110, 3, 1'b1);

    // Write coinciding with update, then a write held across the switch.
    set_cfg(2, 5, 1, 200, 200, 50, 50);
    cfg_valid = 1'b1; update = 1'b1; level = 2'd2;
    tick();
    update = 1'b0;
    cfg_write(2, 6, 1, 300, 300, 10, 10, waited);
    check("held_write_wait", waited, 2);
    pix_check("l2_hit_e5", 210, 210, 5, 1'b1);
    pix_check("l2_hit_e6", 305, 305, 6, 1'b1);

    // Randomized run; a stalled write keeps its fields until accepted.
    acc = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      xCount = CW'($urandom_range(0, 1023));
      yCount = CW'($urandom_range(0, 1023));
      update = ($urandom_range(0, 39) == 0);
      level  = LW'($urandom_range(0, 3));
      if (!cfg_valid || acc) begin
        cfg_valid = ($urandom_range(0, 2) == 0);
        set_cfg($urandom_range(0, 3), $urandom_range(0, 15), int'($urandom_range(0, 3) != 0),
                $urandom_range(0, 1023), $urandom_range(0, 1023),
                $urandom_range(0, 400), $urandom_range(0, 400));
      end
      acc_next = cfg_valid && cfg_ready;
      tick();
      acc = acc_next;
    end
    cfg_valid = 1'b0; update = 1'b0;
    repeat (4) tick();

    // Reset in the middle of a switch.
    tgt = (m_act == 0) ? 1 : 0;
    update = 1'b1; level = LW'(tgt);
    tick();
    update = 1'b0;
    check("pre_reset_in_switch", cfg_ready, 0);
    #2 rst = 1'b0;
    #1;
    check("midrst_wall", wall, 0);
    check("midrst_any", wall_any, 0);
    check("midrst_ready", cfg_ready, 0);
    check("midrst_err", cfg_err, 0);
    check("midrst_level", active_level, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      xCount = CW'($urandom_range(0, 1023));
      yCount = CW'($urandom_range(0, 1023));
      tick();
      check("post_reset_no_hit", wall_any, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
